// File: rtl/ssd_scan_engine.sv
// Self-timed multiplexed 7-segment scan controller with double-buffered digit data,
// per-digit blank/blink masks. Define SSD_LZB_EN to enable leading-zero blanking.
module ssd_scan_engine #(
   parameter int unsigned DIGITS       = 4,
   parameter int unsigned BCD_W        = 4,
   parameter int unsigned SCAN_DIV     = 17,
   parameter int unsigned BLINK_FRAMES = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DIGITS*BCD_W-1:0]   digits_in,
   input  logic [DIGITS-1:0]         blank_in,
   input  logic [DIGITS-1:0]         blink_in,
   input  logic                      load,
   output logic                      load_ack,
   output logic [DIGITS-1:0]         ssd_ctl,
   output logic [BCD_W-1:0]          ssd_in,
   output logic                      frame_start
);

   localparam int unsigned DW    = DIGITS * BCD_W;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [SCAN_DIV-1:0] cnt_q,        cnt_d;
   logic [IDX_W-1:0]    idx_q,        idx_d;
   logic [FC_W-1:0]     fcnt_q,       fcnt_d;
   logic                phase_off_q,  phase_off_d;
   logic                pend_q,       pend_d;
   logic [DW-1:0]       pend_dig_q,   pend_dig_d;
   logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
   logic [DIGITS-1:0]   pend_blink_q, pend_blink_d;
   logic [DW-1:0]       disp_dig_q,   disp_dig_d;
   logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;
   logic [DIGITS-1:0]   disp_blink_q, disp_blink_d;
   logic [DIGITS-1:0]   ssd_ctl_q,    ssd_ctl_d;
   logic [BCD_W-1:0]    ssd_in_q,     ssd_in_d;
   logic                load_ack_q,   load_ack_d;
   logic                fs_q,         fs_d;

   logic                tick_c;
   logic                boundary_c;
   logic                dark_c;
   logic [DIGITS-1:0]   lz_c;

`ifdef SSD_LZB_EN
   // A digit is leading-zero dark while it and every higher digit hold code 0; digit 0 never.
   always_comb begin
      logic run;
      run  = 1'b1;
      lz_c = '0;
      for (int k = DIGITS - 1; k >= 1; k--) begin
         run     = run & (disp_dig_d[k*BCD_W +: BCD_W] == '0);
         lz_c[k] = run;
      end
   end
`else
   assign lz_c = '0;
`endif

   // Next-state and registered-output computation
   always_comb begin
      tick_c       = &cnt_q;
      boundary_c   = tick_c && (idx_q == IDX_W'(DIGITS - 1));

      cnt_d        = cnt_q + SCAN_DIV'(1);
      idx_d        = idx_q;
      fcnt_d       = fcnt_q;
      phase_off_d  = phase_off_q;
      pend_d       = pend_q;
      pend_dig_d   = pend_dig_q;
      pend_blank_d = pend_blank_q;
      pend_blink_d = pend_blink_q;
      disp_dig_d   = disp_dig_q;
      disp_blank_d = disp_blank_q;
      disp_blink_d = disp_blink_q;
      load_ack_d   = 1'b0;
      fs_d         = boundary_c;
      ssd_ctl_d    = '1;
      ssd_in_d     = '0;
      dark_c       = 1'b0;

      if (tick_c) begin
         idx_d = boundary_c ? '0 : idx_q + IDX_W'(1);
      end

      if (load) begin
         pend_d       = 1'b1;
         pend_dig_d   = digits_in;
         pend_blank_d = blank_in;
         pend_blink_d = blink_in;
      end

      // Commit at frame end; a load landing on the boundary bypasses the pending buffer
      if (boundary_c) begin
         if (load) begin
            disp_dig_d   = digits_in;
            disp_blank_d = blank_in;
            disp_blink_d = blink_in;
            pend_d       = 1'b0;
            load_ack_d   = 1'b1;
         end else if (pend_q) begin
            disp_dig_d   = pend_dig_q;
            disp_blank_d = pend_blank_q;
            disp_blink_d = pend_blink_q;
            pend_d       = 1'b0;
            load_ack_d   = 1'b1;
         end
         if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
            fcnt_d      = '0;
            phase_off_d = ~phase_off_q;
         end else begin
            fcnt_d = fcnt_q + FC_W'(1);
         end
      end

      for (int k = 0; k < DIGITS; k++) begin
         if (idx_d == IDX_W'(k)) begin
            ssd_in_d = disp_dig_d[k*BCD_W +: BCD_W];
            dark_c   = disp_blank_d[k] | (disp_blink_d[k] & phase_off_d) | lz_c[k];
         end
      end
      for (int k = 0; k < DIGITS; k++) begin
         if (!dark_c && (idx_d == IDX_W'(k))) begin
            ssd_ctl_d[k] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         fcnt_q       <= '0;
         phase_off_q  <= 1'b0;
         pend_q       <= 1'b0;
         pend_dig_q   <= '0;
         pend_blank_q <= '0;
         pend_blink_q <= '0;
         disp_dig_q   <= '0;
         disp_blank_q <= '1;
         disp_blink_q <= '0;
         ssd_ctl_q    <= '1;
         ssd_in_q     <= '0;
         load_ack_q   <= 1'b0;
         fs_q         <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         fcnt_q       <= fcnt_d;
         phase_off_q  <= phase_off_d;
         pend_q       <= pend_d;
         pend_dig_q   <= pend_dig_d;
         pend_blank_q <= pend_blank_d;
         pend_blink_q <= pend_blink_d;
         disp_dig_q   <= disp_dig_d;
         disp_blank_q <= disp_blank_d;
         disp_blink_q <= disp_blink_d;
         ssd_ctl_q    <= ssd_ctl_d;
         ssd_in_q     <= ssd_in_d;
         load_ack_q   <= load_ack_d;
         fs_q         <= fs_d;
      end
   end

   assign ssd_ctl     = ssd_ctl_q;
   assign ssd_in      = ssd_in_q;
   assign load_ack    = load_ack_q;
   assign frame_start = fs_q;

endmodule

// File: tb/tb_ssd_scan_engine.sv
// Directed bench for ssd_scan_engine: SCAN_DIV=2 (tick every 4 clk), DIGITS=4, BLINK_FRAMES=2.
module tb_ssd_scan_engine;

   localparam int unsigned DIGITS       = 4;
   localparam int unsigned BCD_W        = 4;
   localparam int unsigned SCAN_DIV     = 2;
   localparam int unsigned BLINK_FRAMES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digits_in;
   logic [3:0]  blank_in;
   logic [3:0]  blink_in;
   logic        load;
   logic        load_ack;
   logic [3:0]  ssd_ctl;
   logic [3:0]  ssd_in;
   logic        frame_start;

   int n_checks = 0;
   int n_fail   = 0;

   ssd_scan_engine #(
      .DIGITS(DIGITS), .BCD_W(BCD_W), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
   ) dut (
      .clk(clk), .rst(rst), .digits_in(digits_in), .blank_in(blank_in), .blink_in(blink_in),
      .load(load), .load_ack(load_ack), .ssd_ctl(ssd_ctl), .ssd_in(ssd_in),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   // Advance on negedges until frame_start is seen, counting load_ack pulses on the way.
   task automatic wait_fs(output int acks);
      bit found;
      found = 1'b0;
      acks  = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (load_ack === 1'b1) acks++;
         if (frame_start === 1'b1) found = 1'b1;
      end
      if (!found) begin
         n_checks++; n_fail++;
         $display("FAIL wait_fs: frame_start not seen within 40 cycles, required 1");
      end
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk);
      digits_in = d; blank_in = bl; blink_in = bk; load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic test_reset;
      int acks;
      rst = 1'b1; load = 1'b0; digits_in = '0; blank_in = '0; blink_in = '0;
      #12;
      n_checks++; if (ssd_ctl !== 4'b1111) begin n_fail++; $display("FAIL reset_ctl: got %b required 1111", ssd_ctl); end
      n_checks++; if (ssd_in !== 4'h0) begin n_fail++; $display("FAIL reset_in: got %h required 0", ssd_in); end
      n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b required 0", load_ack); end
      n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b required 0", frame_start); end
      @(negedge clk); rst = 1'b0;
      // With no load the display stays dark across frames
      for (int f = 0; f < 2; f++) begin
         wait_fs(acks);
         n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL noload_ack: got %0d required 0", acks); end
         n_checks++; if (ssd_ctl !== 4'b1111) begin n_fail++; $display("FAIL noload_ctl: got %b required 1111", ssd_ctl); end
         repeat (6) @(negedge clk);
         n_checks++; if (ssd_ctl !== 4'b1111) begin n_fail++; $display("FAIL noload_mid_ctl: got %b required 1111", ssd_ctl); end
      end
   endtask

   task automatic test_basic;
      int acks;
      logic [3:0]  exp_ctl;
      logic [15:0] d;
      d = 16'h4321;
      do_load(d, 4'b0000, 4'b0000);
      wait_fs(acks);
      n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL basic_ackcount: got %0d required 1", acks); end
      n_checks++; if (load_ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack_with_fs: got %b required 1", load_ack); end
      for (int f = 0; f < 2; f++) begin
         if (f == 1) begin
            wait_fs(acks);
            n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL basic_no_reack: got %0d required 0", acks); end
         end
         for (int k = 0; k < 4; k++) begin
            exp_ctl = 4'b1111; exp_ctl[k] = 1'b0;
            n_checks++; if (ssd_ctl !== exp_ctl) begin n_fail++; $display("FAIL basic_ctl[%0d]: got %b required %b", k, ssd_ctl, exp_ctl); end
            n_checks++; if (ssd_in !== d[k*4 +: 4]) begin n_fail++; $display("FAIL basic_in[%0d]: got %h required %h", k, ssd_in, d[k*4 +: 4]); end
            if (k < 3) repeat (4) @(negedge clk);
         end
      end
   endtask

   task automatic test_async_reset;
      int acks;
      // Currently showing digit 3 (code 4); reset lands mid-cycle
      @(posedge clk); #3 rst = 1'b1; #1;
      n_checks++; if (ssd_ctl !== 4'b1111) begin n_fail++; $display("FAIL async_ctl: got %b required 1111", ssd_ctl); end
      n_checks++; if (ssd_in !== 4'h0) begin n_fail++; $display("FAIL async_in: got %h required 0", ssd_in); end
      n_checks++; if (load_ack !== 1'b0) begin n_fail++; $display("FAIL async_ack: got %b required 0", load_ack); end
      @(negedge clk); rst = 1'b0;
      // A pending load interrupted by reset is discarded
      do_load(16'h9999, 4'b0000, 4'b0000);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int f = 0; f < 2; f++) begin
         wait_fs(acks);
         n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL discard_ack: got %0d required 0", acks); end
         n_checks++; if (ssd_ctl !== 4'b1111) begin n_fail++; $display("FAIL discard_ctl: got %b required 1111", ssd_ctl); end
         n_checks++; if (ssd_in !== 4'h0) begin n_fail++; $display("FAIL discard_in: got %h required 0", ssd_in); end
      end
   endtask

   task automatic test_double_load;
      int acks;
      logic [3:0] exp_ctl;
      do_load(16'h1111, 4'b0000, 4'b0000);
      do_load(16'h2222, 4'b0000, 4'b0000);
      wait_fs(acks);
      n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL dbl_ackcount: got %0d required 1", acks); end
      for (int k = 0; k < 4; k++) begin
         exp_ctl = 4'b1111; exp_ctl[k] = 1'b0;
         n_checks++; if (ssd_ctl !== exp_ctl) begin n_fail++; $display("FAIL dbl_ctl[%0d]: got %b required %b", k, ssd_ctl, exp_ctl); end
         n_checks++; if (ssd_in !== 4'h2) begin n_fail++; $display("FAIL dbl_in[%0d]: got %h required 2", k, ssd_in); end
         if (k < 3) repeat (4) @(negedge clk);
      end
      wait_fs(acks);
      n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL dbl_second_ack: got %0d required 0", acks); end
   endtask

   task automatic test_boundary_load;
      int acks;
      // From the frame_start sample, the boundary tick cycle is 15 cycles later
      repeat (15) @(negedge clk);
      n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL bnd_pre_fs: got %b required 0", frame_start); end
      n_checks++; if (ssd_ctl !== 4'b0111) begin n_fail++; $display("FAIL bnd_pre_ctl: got %b required 0111", ssd_ctl); end
      n_checks++; if (ssd_in !== 4'h2) begin n_fail++; $display("FAIL bnd_pre_in: got %h required 2", ssd_in); end
      do_load(16'h8765, 4'b0000, 4'b0000);
      n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL bnd_fs: got %b required 1", frame_start); end
      n_checks++; if (load_ack !== 1'b1) begin n_fail++; $display("FAIL bnd_ack: got %b required 1", load_ack); end
      n_checks++; if (ssd_ctl !== 4'b1110) begin n_fail++; $display("FAIL bnd_ctl: got %b required 1110", ssd_ctl); end
      n_checks++; if (ssd_in !== 4'h5) begin n_fail++; $display("FAIL bnd_in: got %h required 5", ssd_in); end
      wait_fs(acks);
      n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL bnd_no_pending: got %0d required 0", acks); end
   endtask

   task automatic test_blink;
      int acks;
      logic [5:0] lit0;
      logic [3:0] exp_ctl;
      // Frames after reset: first boundary keeps phase on, then toggles every 2 frames
      lit0 = 6'b011001;
      @(posedge clk); #2 rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      do_load(16'h4321, 4'b0000, 4'b0001);
      for (int f = 0; f < 6; f++) begin
         wait_fs(acks);
         exp_ctl = lit0[f] ? 4'b1110 : 4'b1111;
         n_checks++; if (ssd_ctl !== exp_ctl) begin n_fail++; $display("FAIL blink_d0 frame %0d: got %b required %b", f, ssd_ctl, exp_ctl); end
         n_checks++; if (ssd_in !== 4'h1) begin n_fail++; $display("FAIL blink_in0 frame %0d: got %h required 1", f, ssd_in); end
         repeat (4) @(negedge clk);
         n_checks++; if (ssd_ctl !== 4'b1101) begin n_fail++; $display("FAIL blink_d1 frame %0d: got %b required 1101", f, ssd_ctl); end
      end
   endtask

   task automatic test_zeros;
      int acks;
      logic [3:0]  lit;
      logic [3:0]  exp_ctl;
      logic [15:0] d;
      for (int t = 0; t < 2; t++) begin
         d = (t == 0) ? 16'h0070 : 16'h0000;
`ifdef SSD_LZB_EN
         lit = (t == 0) ? 4'b0011 : 4'b0001;
`else
         lit = 4'b1111;
`endif
         do_load(d, 4'b0000, 4'b0000);
         wait_fs(acks);
         for (int k = 0; k < 4; k++) begin
            exp_ctl = 4'b1111;
            if (lit[k]) exp_ctl[k] = 1'b0;
            n_checks++; if (ssd_ctl !== exp_ctl) begin n_fail++; $display("FAIL zero%0d_ctl[%0d]: got %b required %b", t, k, ssd_ctl, exp_ctl); end
            n_checks++; if (ssd_in !== d[k*4 +: 4]) begin n_fail++; $display("FAIL zero%0d_in[%0d]: got %h required %h", t, k, ssd_in, d[k*4 +: 4]); end
            if (k < 3) repeat (4) @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_async_reset;
      test_double_load;
      test_boundary_load;
      test_blink;
      test_zeros;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
